instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch controller: consumer of the program counter. Reads PC_in, issues req/ack reads to instruction
//   memory, latches the word into IR for decode, and drives PC_inc/PC_ld back to the program counter.
//   Sits between the PC register, instruction memory and the decode stage. Handles redirect (flush),
//   a memory timeout and a misaligned-PC fault.
// PARAMETERS
//   TIMEOUT_CYCLES  16  max cycles mem_req may wait for mem_ack before fault (>=2)
//   CNT_W           32  width of fetch_count
// PORTS
//   clk          in   1      clock, all state on posedge
//   reset        in   1      synchronous, active-low reset
//   fetch_en     in   1      enable fetching
//   PC_in        in   32     current PC value from program counter
//   PC_inc       out  1      1-cycle pulse: PC advances by 4
//   PC_ld        out  1      1-cycle pulse: PC loads PC_ld_val
//   PC_ld_val    out  32     redirect target driven with PC_ld
//   flush        in   1      redirect request from execute
//   flush_target in   32     redirect address
//   mem_req      out  1      read request, held until mem_ack
//   mem_addr     out  32     read address (= PC_in captured at request)
//   mem_ack      in   1      read data valid this cycle
//   mem_rdata    in   32     instruction word
//   IR_out       out  32     latched instruction
//   IR_valid     out  1      IR_out holds an undelivered instruction
//   IR_ready     in   1      decode accepts IR_out when IR_valid & IR_ready
//   fault        out  1      sticky: timeout or misaligned PC
//   fetch_count  out  CNT_W  instructions delivered to decode, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE; all outputs 0 (IR_out, PC_ld_val, mem_addr, fetch_count,
//     fault included); timeout counter cleared. Reset mid-transaction abandons it; no ack tracking.
//   States: IDLE, REQ, HOLD, DRAIN, FAULT.
//   IDLE: fetch_en=1 -> PC_in[1:0]!=0 ? FAULT : REQ with mem_addr<=PC_in, mem_req<=1.
//   REQ: mem_req=1, mem_addr stable. On mem_ack: IR_out<=mem_rdata, IR_valid<=1, PC_inc=1 for one cycle,
//     mem_req<=0, -> HOLD. Timeout counter increments each REQ cycle without ack; reaching
//     TIMEOUT_CYCLES -> FAULT, mem_req<=0.
//   HOLD: IR_valid=1. On IR_ready: fetch_count+1; if fetch_en & PC_in aligned -> REQ (new request
//     issued next cycle, mem_addr<=PC_in already incremented), else -> IDLE with IR_valid<=0.
//     Misaligned -> FAULT. Back-to-back throughput: one instruction per 2 cycles with 0-wait memory.
//   Flush (any state except FAULT, highest priority): PC_ld=1 and PC_ld_val=flush_target for one cycle,
//     IR_valid<=0, PC_inc suppressed. Flush in REQ without ack same cycle -> DRAIN. Flush with ack same
//     cycle: data discarded, -> IDLE. Flush in IDLE/HOLD -> IDLE. fetch_count unchanged on flush.
//   DRAIN: mem_req held until mem_ack, data discarded, no PC_inc; then -> IDLE. Flush in DRAIN
//     re-issues PC_ld with the new target, stays DRAIN. Timeout applies as in REQ.
//   FAULT: mem_req=0, IR_valid=0, no PC_inc/PC_ld; fault=1; exit only by reset.
//   PC_inc and PC_ld never both 1. PC_inc occurs exactly once per accepted non-flushed ack.
//   mem_req never drops before mem_ack except on timeout or reset.
//   fetch_en deassert during REQ does not cancel the request; the instruction is still delivered.
// TESTING
//   T1 reset=0 2 cycles, PC_in=0, fetch_en=1, mem_ack 1 cycle after req, rdata=0x20080005, IR_ready=1
//      -> mem_addr=0, IR_out=0x20080005, one PC_inc pulse, fetch_count=1.
//   T2 stream PC 0,4,8 with 3-cycle ack latency, IR_ready held 0 for 4 cycles on 2nd word
//      -> IR_out stable while IR_valid, no 3rd req until handshake, fetch_count=3, exactly 3 PC_inc.
//   T3 flush=1, flush_target=0x40 while in REQ, ack 2 cycles later -> PC_ld pulse val 0x40, DRAIN holds
//      mem_req until ack, data dropped, no PC_inc, IR_valid stays 0, next mem_addr=0x40.
//   T4 flush and mem_ack in same cycle -> PC_ld=1, PC_inc=0, IR_valid=0, fetch_count unchanged.
//   T5 mem_ack never asserted, TIMEOUT_CYCLES=16 -> fault=1 after 16 REQ cycles, mem_req=0, sticky
//      until reset; PC_in=0x6 in IDLE with fetch_en -> fault, no mem_req.
//   T6 reset=0 during REQ/HOLD -> next cycle all outputs 0, state IDLE; CNT_W=4 wrap 15->0 verified.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: request/address out of the fetch unit, ack/data back.
interface instr_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch controller: issues instruction-memory reads at PC_in, latches IR for decode,
// drives PC_inc/PC_ld, and handles flush redirects, memory timeout and misaligned-PC faults.
module instr_fetch_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_en,
  input  logic [31:0]          PC_in,
  output logic                 PC_inc,
  output logic                 PC_ld,
  output logic [31:0]          PC_ld_val,
  input  logic                 flush,
  input  logic [31:0]          flush_target,
  instr_fetch_unit_if.master   mem,
  output logic [31:0]          IR_out,
  output logic                 IR_valid,
  input  logic                 IR_ready,
  output logic                 fault,
  output logic [CNT_W-1:0]     fetch_count
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, FAULT} state_t;

  state_t            state, state_nxt;
  logic              req_q, req_nxt;
  logic [31:0]       addr_q, addr_nxt;
  logic [31:0]       ir_q, ir_nxt;
  logic              irv_q, irv_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [TO_W-1:0]   to_q, to_nxt;
  logic              inc, ld;
  logic              pc_ok;

  assign pc_ok = (PC_in[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      addr_q <= '0;
      ir_q   <= '0;
      irv_q  <= 1'b0;
      cnt_q  <= '0;
      to_q   <= '0;
    end else begin
      state  <= state_nxt;
      req_q  <= req_nxt;
      addr_q <= addr_nxt;
      ir_q   <= ir_nxt;
      irv_q  <= irv_nxt;
      cnt_q  <= cnt_nxt;
      to_q   <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    addr_nxt  = addr_q;
    ir_nxt    = ir_q;
    irv_nxt   = irv_q;
    cnt_nxt   = cnt_q;
    to_nxt    = to_q;
    inc       = 1'b0;
    ld        = (state != FAULT) && flush;
    case (state)
      IDLE: begin
        if (!flush && fetch_en) begin
          if (!pc_ok) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = REQ;
            req_nxt   = 1'b1;
            addr_nxt  = PC_in;
            to_nxt    = '0;
          end
        end
      end
      REQ, DRAIN: begin
        if (mem.mem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
          // Only a clean REQ keeps its data; a flush (now or earlier) drops it.
          if (state == REQ && !flush) begin
            ir_nxt    = mem.mem_rdata;
            irv_nxt   = 1'b1;
            inc       = 1'b1;
            state_nxt = HOLD;
          end
        end else begin
          to_nxt = to_q + 1'b1;
          if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = FAULT;
            req_nxt   = 1'b0;
          end else if (flush) begin
            state_nxt = DRAIN;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          irv_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (IR_ready) begin
          cnt_nxt = cnt_q + 1'b1;
          irv_nxt = 1'b0;
          // PC_in has already advanced via the PC_inc pulse on the ack cycle.
          if (!fetch_en) begin
            state_nxt = IDLE;
          end else if (!pc_ok) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = REQ;
            req_nxt   = 1'b1;
            addr_nxt  = PC_in;
            to_nxt    = '0;
          end
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign PC_inc       = reset && inc;
  assign PC_ld        = reset && ld;
  assign PC_ld_val    = PC_ld ? flush_target : 32'h0;
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign IR_out       = ir_q;
  assign IR_valid     = irv_q;
  assign fault        = (state == FAULT);
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register and memory responder environment, a
// transaction-level reference model checked every cycle, directed scenarios plus random traffic.
module tb_instr_fetch_unit;
  localparam int TO = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, fetch_en, flush, IR_ready;
  logic [31:0]   PC_in, flush_target;
  logic          PC_inc, PC_ld, IR_valid, fault;
  logic [31:0]   PC_ld_val, IR_out;
  logic [CW-1:0] fetch_count;

  instr_fetch_unit_if mif();

  instr_fetch_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .PC_in(PC_in),
    .PC_inc(PC_inc), .PC_ld(PC_ld), .PC_ld_val(PC_ld_val),
    .flush(flush), .flush_target(flush_target), .mem(mif),
    .IR_out(IR_out), .IR_valid(IR_valid), .IR_ready(IR_ready),
    .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h20080005;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Environment: program-counter register and handshake observers
  logic [31:0] pc_reg = 32'h0;
  logic [31:0] pc_force_val = 32'h0;
  bit          pc_force = 1'b0;
  int          inc_seen = 0, ld_seen = 0, del_seen = 0;
  assign PC_in = pc_reg;

  always @(posedge clk) begin
    if (pc_force)    pc_reg <= pc_force_val;
    else if (PC_ld)  pc_reg <= PC_ld_val;
    else if (PC_inc) pc_reg <= pc_reg + 32'd4;
    if (PC_inc === 1'b1) inc_seen <= inc_seen + 1;
    if (PC_ld === 1'b1)  ld_seen  <= ld_seen + 1;
    if (reset && IR_valid === 1'b1 && IR_ready && !flush) del_seen <= del_seen + 1;
  end

  // Memory responder (runs inside tick, at the falling edge)
  int lat = 1, wcnt = 0;
  bit resp_off = 1'b0, rand_lat = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (mif.mem_req === 1'b1 && !resp_off) begin
      if (wcnt >= lat) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = mem_word(mif.mem_addr);
        wcnt = 0;
        if (rand_lat) lat = ($urandom % 40 == 0) ? 18 : int'($urandom_range(0, 4));
      end else begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = $urandom;
      wcnt = 0;
    end
    #1;
  endtask

  // Reference model: one outstanding read (maybe doomed by a flush), one held word, sticky fault
  bit          mdl_on = 1'b0;
  bit          m_fault, m_pend, m_drop, m_have;
  logic [31:0] m_addr, m_ir;
  int          m_wait, m_count;

  initial forever begin
    bit e_ld, e_inc, launch;
    @(negedge clk);
    #2;
    e_ld  = reset && flush && !m_fault;
    e_inc = reset && m_pend && !m_drop && mif.mem_ack && !flush;
    if (mdl_on) begin
      chk("mem_req", 32'(mif.mem_req), 32'(m_pend));
      if (m_pend) chk("mem_addr", mif.mem_addr, m_addr);
      chk("IR_valid", 32'(IR_valid), 32'(m_have));
      if (m_have) chk("IR_out", IR_out, m_ir);
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fetch_count", 32'(fetch_count), 32'(m_count % (1 << CW)));
      chk("PC_inc", 32'(PC_inc), 32'(e_inc));
      chk("PC_ld", 32'(PC_ld), 32'(e_ld));
      if (e_ld) chk("PC_ld_val", PC_ld_val, flush_target);
    end
    launch = 1'b0;
    if (!reset) begin
      m_fault = 0; m_pend = 0; m_drop = 0; m_have = 0;
      m_addr = 0; m_ir = 0; m_wait = 0; m_count = 0;
    end else if (!m_fault) begin
      if (m_pend) begin
        if (mif.mem_ack) begin
          m_pend = 0;
          if (!m_drop && !flush) begin m_have = 1; m_ir = mif.mem_rdata; end
          m_drop = 0;
        end else begin
          m_wait++;
          if (m_wait >= TO) begin m_fault = 1; m_pend = 0; m_drop = 0; end
          else if (flush) m_drop = 1;
        end
      end else if (m_have) begin
        if (flush) m_have = 0;
        else if (IR_ready) begin m_count++; m_have = 0; launch = fetch_en; end
      end else if (!flush && fetch_en) begin
        launch = 1'b1;
      end
      if (launch) begin
        if (PC_in[1:0] != 2'b00) m_fault = 1;
        else begin m_pend = 1; m_addr = PC_in; m_wait = 0; m_drop = 0; end
      end
    end
  end

  task automatic do_reset(input logic [31:0] pc0);
    reset = 1'b0; fetch_en = 1'b0; flush = 1'b0; IR_ready = 1'b0;
    resp_off = 1'b0; rand_lat = 1'b0;
    pc_force = 1'b1; pc_force_val = pc0;
    tick(); tick();
    pc_force = 1'b0; reset = 1'b1; mdl_on = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mif.mem_req), 32'h0);
    chk({tag, "_mem_addr"},  mif.mem_addr,     32'h0);
    chk({tag, "_IR_out"},    IR_out,           32'h0);
    chk({tag, "_IR_valid"},  32'(IR_valid),    32'h0);
    chk({tag, "_fault"},     32'(fault),       32'h0);
    chk({tag, "_count"},     32'(fetch_count), 32'h0);
    chk({tag, "_PC_inc"},    32'(PC_inc),      32'h0);
    chk({tag, "_PC_ld"},     32'(PC_ld),       32'h0);
    chk({tag, "_PC_ld_val"}, PC_ld_val,        32'h0);
  endtask

  int i0, l0, d0, rq;

  initial begin
    reset = 1'b0; fetch_en = 1'b0; flush = 1'b0; flush_target = 32'h0; IR_ready = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;

    // T1: single fetch at PC 0
    do_reset(32'h0);
    chk_zero("t1_rst");
    lat = 1; IR_ready = 1'b1; fetch_en = 1'b1; i0 = inc_seen; d0 = del_seen;
    tick();
    chk("t1_mem_req", 32'(mif.mem_req), 32'h1);
    chk("t1_mem_addr", mif.mem_addr, 32'h0);
    fetch_en = 1'b0;
    for (int n = 0; n < 20 && IR_valid !== 1'b1; n++) tick();
    chk("t1_IR_valid", 32'(IR_valid), 32'h1);
    chk("t1_IR_out", IR_out, 32'h20080005);
    for (int n = 0; n < 20 && del_seen - d0 < 1; n++) tick();
    chk("t1_count", 32'(fetch_count), 32'd1);
    chk("t1_inc", 32'(inc_seen - i0), 32'd1);

    // T2: stream 0,4,8 with 3-cycle latency and a stalled decode on the 2nd word
    do_reset(32'h0);
    lat = 3; fetch_en = 1'b1; IR_ready = 1'b1; i0 = inc_seen; d0 = del_seen;
    for (int n = 0; n < 30 && del_seen - d0 < 1; n++) tick();
    IR_ready = 1'b0;
    for (int n = 0; n < 30 && IR_valid !== 1'b1; n++) tick();
    chk("t2_IR_valid", 32'(IR_valid), 32'h1);
    for (int n = 0; n < 4; n++) begin
      chk("t2_IR_hold", IR_out, mem_word(32'h4));
      chk("t2_no_req", 32'(mif.mem_req), 32'h0);
      tick();
    end
    IR_ready = 1'b1;
    for (int n = 0; n < 40 && del_seen - d0 < 3; n++) tick();
    chk("t2_count", 32'(fetch_count), 32'd3);
    chk("t2_inc", 32'(inc_seen - i0), 32'd3);
    chk("t2_pc", PC_in, 32'hC);
    fetch_en = 1'b0;

    // T3: flush during REQ, ack two cycles later is drained
    do_reset(32'h0);
    lat = 2; fetch_en = 1'b1; IR_ready = 1'b1;
    tick();
    flush = 1'b1; flush_target = 32'h40; fetch_en = 1'b0; i0 = inc_seen; l0 = ld_seen;
    tick();
    flush = 1'b0;
    chk("t3_ld", 32'(ld_seen - l0), 32'd1);
    chk("t3_pc", PC_in, 32'h40);
    chk("t3_drain_req", 32'(mif.mem_req), 32'h1);
    tick(); tick();
    chk("t3_req_done", 32'(mif.mem_req), 32'h0);
    chk("t3_IR_valid", 32'(IR_valid), 32'h0);
    chk("t3_inc", 32'(inc_seen - i0), 32'd0);
    fetch_en = 1'b1;
    tick();
    chk("t3_new_addr", mif.mem_addr, 32'h40);
    fetch_en = 1'b0;

    // T4: flush and ack in the same cycle
    do_reset(32'h0);
    lat = 1; fetch_en = 1'b1; IR_ready = 1'b1;
    tick(); tick();
    chk("t4_ack", 32'(mif.mem_ack), 32'h1);
    flush = 1'b1; flush_target = 32'h80; fetch_en = 1'b0; i0 = inc_seen; l0 = ld_seen;
    tick();
    flush = 1'b0;
    chk("t4_IR_valid", 32'(IR_valid), 32'h0);
    chk("t4_inc", 32'(inc_seen - i0), 32'd0);
    chk("t4_ld", 32'(ld_seen - l0), 32'd1);
    chk("t4_count", 32'(fetch_count), 32'd0);
    chk("t4_pc", PC_in, 32'h80);

    // T5: timeout, stickiness, then misaligned PC
    do_reset(32'h0);
    resp_off = 1'b1; fetch_en = 1'b1; rq = 0;
    tick();
    fetch_en = 1'b0;
    for (int n = 0; n < 40 && fault !== 1'b1; n++) begin
      if (mif.mem_req === 1'b1) rq++;
      tick();
    end
    chk("t5_req_cycles", 32'(rq), 32'd16);
    chk("t5_fault", 32'(fault), 32'h1);
    chk("t5_req_off", 32'(mif.mem_req), 32'h0);
    resp_off = 1'b0; fetch_en = 1'b1; flush = 1'b1; flush_target = 32'h100;
    for (int n = 0; n < 5; n++) tick();
    flush = 1'b0;
    chk("t5_sticky", 32'(fault), 32'h1);
    do_reset(32'h6);
    chk("t5_fault_clr", 32'(fault), 32'h0);
    fetch_en = 1'b1;
    tick();
    chk("t5_misaligned", 32'(fault), 32'h1);
    chk("t5_mis_req", 32'(mif.mem_req), 32'h0);

    // T6: reset mid-REQ and mid-HOLD, then counter wrap
    do_reset(32'h0);
    lat = 1; fetch_en = 1'b1; IR_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk_zero("t6_req");
    reset = 1'b1;
    for (int n = 0; n < 20 && IR_valid !== 1'b1; n++) tick();
    chk("t6_hold", 32'(IR_valid), 32'h1);
    reset = 1'b0;
    tick();
    chk_zero("t6_hold");
    reset = 1'b1;
    do_reset(32'h0);
    lat = 0; fetch_en = 1'b1; IR_ready = 1'b1; d0 = del_seen;
    for (int n = 0; n < 100 && del_seen - d0 < 15; n++) tick();
    chk("t6_count15", 32'(fetch_count), 32'd15);
    for (int n = 0; n < 20 && del_seen - d0 < 16; n++) tick();
    chk("t6_wrap", 32'(fetch_count), 32'd0);

    // Random traffic
    do_reset(32'h0);
    rand_lat = 1'b1; lat = 1;
    for (int n = 0; n < 4000; n++) begin
      reset        = !($urandom % 200 == 0 || (fault === 1'b1 && $urandom % 10 == 0));
      fetch_en     = ($urandom % 5 != 0);
      IR_ready     = ($urandom % 5 < 3);
      flush        = ($urandom % 25 == 0);
      flush_target = (32'($urandom_range(0, 255)) << 2) | (($urandom % 30 == 0) ? 32'h2 : 32'h0);
      tick();
    end
    reset = 1'b1; flush = 1'b0; fetch_en = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
